// File: rtl/ser_pkg.sv
// Shared definitions for the start/data/end serial link (transmitter and receiver).
package ser_pkg;

    localparam int         SER_WIDTH   = 8;
    localparam logic [7:0] ERR_CNT_MAX = 8'd255;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RECV = 1'b1
    } ser_state_t;

endpackage

// File: rtl/serial2parallel_if.sv
// Serial link plus reassembled-word bus; master drives the serial side, slave is the receiver.
interface serial2parallel_if #(
    parameter int WIDTH = ser_pkg::SER_WIDTH
);

    logic             serial_start;
    logic             serial_in;
    logic             serial_end;
    logic [WIDTH-1:0] parallel_out;
    logic             parallel_valid;
    logic             frame_err;
    logic [7:0]       err_count;

    modport master (
        output serial_start, serial_in, serial_end,
        input  parallel_out, parallel_valid, frame_err, err_count
    );

    modport slave (
        input  serial_start, serial_in, serial_end,
        output parallel_out, parallel_valid, frame_err, err_count
    );

endinterface

// File: rtl/serial2parallel.sv
// Serial-to-parallel receiver: reassembles LSB-first framed words and flags framing errors.
// Optional saturating error counter enabled by defining SER2PAR_ERR_CNT_EN.
module serial2parallel
    import ser_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    serial2parallel_if.slave  bus
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    ser_state_t       state, next_state;
    logic [CW-1:0]    cnt, next_cnt;
    logic [WIDTH-1:0] shift, next_shift;
    logic [WIDTH-1:0] word_q;
    logic             valid_q;
    logic             err_q;
    logic             load;
    logic             err;

    // A start pulse always restarts a frame unless end arrives with it, which is never legal.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_shift = shift;
        load       = 1'b0;
        err        = 1'b0;

        if (bus.serial_start && bus.serial_end) begin
            err        = 1'b1;
            next_state = S_IDLE;
            next_cnt   = '0;
        end else if (bus.serial_start) begin
            err           = (state == S_RECV);
            next_shift[0] = bus.serial_in;
            next_cnt      = CW'(1);
            next_state    = S_RECV;
        end else if (state == S_IDLE) begin
            err = bus.serial_end;
        end else if (cnt == LAST) begin
            next_shift[cnt] = bus.serial_in;
            load            = bus.serial_end;
            err             = !bus.serial_end;
            next_state      = S_IDLE;
            next_cnt        = '0;
        end else if (bus.serial_end) begin
            err        = 1'b1;
            next_state = S_IDLE;
            next_cnt   = '0;
        end else begin
            next_shift[cnt] = bus.serial_in;
            next_cnt        = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            shift <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            shift <= next_shift;
        end
    end

    // Output word only moves on a clean frame, so it survives any number of errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= load;
            err_q   <= err;
            if (load) begin
                word_q <= next_shift;
            end
        end
    end

    assign bus.parallel_out   = word_q;
    assign bus.parallel_valid = valid_q;
    assign bus.frame_err      = err_q;

`ifdef SER2PAR_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else if (err && (err_cnt_q != ERR_CNT_MAX)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bus.err_count = err_cnt_q;
`else
    assign bus.err_count = 8'd0;
`endif

endmodule

// File: tb/tb_serial2parallel.sv
// Scoreboard bench for serial2parallel: directed frames push expected events, a monitor pops them.
module tb_serial2parallel;
    import ser_pkg::*;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    logic [7:0] last_good;
    exp_t exp_q[$];

    serial2parallel_if #(.WIDTH(8)) bus ();

    serial2parallel #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic drive_cycle(input logic s, input logic d, input logic e);
        @(posedge clk);
        #1;
        bus.serial_start = s;
        bus.serial_in    = d;
        bus.serial_end   = e;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic push_exp(input logic is_err, input logic [7:0] data);
        exp_t x;
        x.is_err = is_err;
        x.data   = data;
        exp_q.push_back(x);
    endtask

    task automatic send_frame(input logic [7:0] w);
        for (int i = 0; i < 8; i++) drive_cycle(i == 0, w[i], i == 7);
        push_exp(1'b0, w);
        last_good = w;
    endtask

    // Monitor: every valid or error pulse must match the next queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (bus.parallel_valid || bus.frame_err)) begin
                if (bus.parallel_valid && bus.frame_err) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL overlap: valid and frame_err both high, expected only one");
                end else if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_event: got valid=%b err=%b, expected none",
                             bus.parallel_valid, bus.frame_err);
                end else begin
                    e = exp_q.pop_front();
                    check_val("event_kind_is_err", {7'd0, bus.frame_err}, {7'd0, e.is_err});
                    check_val(e.is_err ? "held_word" : "rx_word", bus.parallel_out, e.data);
                end
            end
        end
    end

    initial begin
        vectors          = 0;
        miscompares      = 0;
        last_good        = 8'h00;
        rst_n            = 1'b0;
        bus.serial_start = 1'b0;
        bus.serial_in    = 1'b0;
        bus.serial_end   = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_val("reset_parallel_out", bus.parallel_out, 8'h00);
        check_val("reset_valid", {7'd0, bus.parallel_valid}, 8'h00);
        check_val("reset_frame_err", {7'd0, bus.frame_err}, 8'h00);
        check_val("reset_err_count", bus.err_count, 8'h00);
        rst_n = 1'b1;
        idle_cycles(2);

        send_frame(8'hA5);
        idle_cycles(3);

        send_frame(8'h3C);
        send_frame(8'hC3);
        send_frame(8'hFF);
        send_frame(8'h00);
        idle_cycles(3);

        // Early end on bit 4 of 8'h5A.
        for (int i = 0; i < 5; i++) drive_cycle(i == 0, 1'(8'h5A >> i), i == 4);
        push_exp(1'b1, last_good);
        idle_cycles(2);
        send_frame(8'h81);
        idle_cycles(2);

        // Start reasserted on bit 3, then a clean frame from that cycle.
        for (int i = 0; i < 3; i++) drive_cycle(i == 0, 1'(8'h5A >> i), 1'b0);
        push_exp(1'b1, last_good);
        send_frame(8'h7E);
        idle_cycles(3);
`ifdef SER2PAR_ERR_CNT_EN
        check_val("err_count_two", bus.err_count, 8'd2);
`else
        check_val("err_count_two", bus.err_count, 8'd0);
`endif

        // Reset mid-frame at bit 5.
        for (int i = 0; i < 5; i++) drive_cycle(i == 0, 1'(8'h99 >> i), 1'b0);
        @(posedge clk);
        #1;
        rst_n            = 1'b0;
        bus.serial_start = 1'b0;
        bus.serial_in    = 1'b0;
        bus.serial_end   = 1'b0;
        #2;
        check_val("midreset_parallel_out", bus.parallel_out, 8'h00);
        check_val("midreset_valid", {7'd0, bus.parallel_valid}, 8'h00);
        check_val("midreset_err_count", bus.err_count, 8'h00);
        last_good = 8'h00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycles(2);
        send_frame(8'h99);
        idle_cycles(2);

        // Illegal control combinations seen from IDLE and a missing end bit.
        drive_cycle(1'b0, 1'b1, 1'b1);
        push_exp(1'b1, last_good);
        idle_cycles(1);
        drive_cycle(1'b1, 1'b1, 1'b1);
        push_exp(1'b1, last_good);
        idle_cycles(2);
        for (int i = 0; i < 8; i++) drive_cycle(i == 0, 1'(8'h55 >> i), 1'b0);
        push_exp(1'b1, last_good);
        idle_cycles(3);
        check_val("hold_after_errors", bus.parallel_out, 8'h99);
`ifdef SER2PAR_ERR_CNT_EN
        check_val("err_count_three", bus.err_count, 8'd3);
`else
        check_val("err_count_three", bus.err_count, 8'd0);
`endif

        // 300 early-end frames drive the counter into saturation.
        for (int f = 0; f < 300; f++) begin
            drive_cycle(1'b1, 1'b1, 1'b0);
            drive_cycle(1'b0, 1'b0, 1'b1);
            push_exp(1'b1, last_good);
        end
        idle_cycles(3);
`ifdef SER2PAR_ERR_CNT_EN
        check_val("err_count_saturated", bus.err_count, 8'd255);
`else
        check_val("err_count_saturated", bus.err_count, 8'd0);
`endif

        send_frame(8'h66);
        idle_cycles(4);
        check_val("final_word", bus.parallel_out, 8'h66);
        check_val("pending_expectations", 8'(exp_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
